arp_tx: RTL and testbench
=========================

Name: arp_tx

Overview:
- GMII-side ARP frame transmitter; the transmit counterpart of the ARP receive parser.
- On a one-cycle request it builds one complete Ethernet II ARP frame: preamble, SFD, 14-byte header, 28-byte ARP body, 18-byte zero pad and 4-byte IEEE 802.3 FCS.
- Sits between arp_ctrl (request/reply decision, destination addresses) and the GMII TX mux in the ARP top level.

Parameters:
- BOARD_MAC, 48'h00_11_22_33_44_55, local MAC; used as Ethernet source and ARP sender MAC.
- BOARD_IP, {8'd192,8'd168,8'd1,8'd10}, local IP; used as ARP sender IP.
- IFG_CYCLES, 12, minimum idle cycles after the FCS before the next frame may start (range 1..255).

Ports:
- i_gmii_tx_clk  in  1  GMII transmit clock (125 MHz); the only clock.
- i_rst  in  1  synchronous reset, active-high.
- i_arp_tx_en  in  1  one-cycle start request; honoured only when o_arp_tx_busy=0.
- i_arp_tx_type  in  1  0: ARP request, 1: ARP reply.
- i_arp_desmac_addr  in  48  target MAC; used for reply only.
- i_arp_desip_addr  in  32  target IP.
- o_gmii_tx_en  out  1  GMII data valid.
- o_gmii_tx_data  out  8  GMII data byte.
- o_arp_tx_done  out  1  one-cycle pulse after the last FCS byte.
- o_arp_tx_busy  out  1  high from the accepted request through the end of the IFG.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; byte counter=0; CRC register=32'hFFFF_FFFF. Reset mid-frame: o_gmii_tx_en and o_gmii_tx_data go to 0 at the reset edge, no done pulse, and no partial FCS is emitted.
- Acceptance: in IDLE, if i_arp_tx_en=1 at edge N, latch type, MAC and IP, and set busy at N. i_arp_tx_en while busy is ignored; it is not queued.
- Latency: o_gmii_tx_en rises at edge N+1 and stays high for exactly 72 consecutive cycles. o_arp_tx_done=1 for the single cycle following the last FCS byte, with o_gmii_tx_en=0 in that cycle.
- FSM states: IDLE -> PREAMBLE -> ETH_HEAD -> ARP_BODY -> PAD -> FCS -> IFG -> IDLE. A byte counter resets on each state entry.
  - PREAMBLE (8 bytes): 7x 8'h55, then 8'hD5.
  - ETH_HEAD (14 bytes): destination MAC, then BOARD_MAC, then 16'h0806. Destination MAC is 48'hFFFF_FFFF_FFFF for a request and the latched MAC for a reply.
  - ARP_BODY (28 bytes): 16'h0001, 16'h0800, 8'h06, 8'h04, opcode 16'h0001 (request) or 16'h0002 (reply), BOARD_MAC, BOARD_IP, target MAC, latched IP. Target MAC is 48'h0 for a request and the latched MAC for a reply.
  - PAD (18 bytes): all 8'h00.
  - FCS (4 bytes): see CRC rules below.
  - IFG (IFG_CYCLES cycles): o_gmii_tx_en=0; busy deasserts on the transition to IDLE.
- Byte order: all multi-byte fields go most-significant byte first.
- CRC rules:
  - IEEE CRC-32 (poly 04C1_1DB7, reflected), initialised to FFFF_FFFF when entering ETH_HEAD.
  - Updated on each of the 60 bytes from ETH_HEAD through PAD; the preamble and SFD are excluded.
  - FCS = ~CRC, bit-reflected, sent least-significant byte first.
  - The CRC update is registered; the FCS byte driven in each cycle comes from the CRC state that includes the last PAD byte.
- Addresses are latched at acceptance. Input changes during a frame have no effect.
- A request presented on the cycle busy falls, or later, is accepted normally.

Decomposition:
- Shared package arp_pkg holds:
  - ETH_TYPE_ARP=16'h0806, ARP_HTYPE=16'h0001, ARP_PTYPE=16'h0800;
  - ARP_OP_REQ=16'h0001, ARP_OP_REPLY=16'h0002;
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - field lengths: ETH_HEAD_LEN=14, ARP_BODY_LEN=28, PAD_LEN=18, FCS_LEN=4;
  - the FSM state enum.
- One sub-module: crc32_d8, a combinational next-CRC for 8 data bits, shared later with the UDP transmitter.

Test Plan:
- Reply: type=1, MAC=48'hA0B1C2D3E4F5, IP=192.168.1.102 -> 72 tx_en cycles.
  - Bytes 8-13 = A0 B1 C2 D3 E4 F5; bytes 20-21 = 08 06; opcode bytes 28-29 = 00 02; last 4 target-IP bytes = C0 A8 01 66.
  - FCS equals the software CRC-32; CRC over bytes 8..71 leaves residue 32'hC704DD7B; done pulses at N+73.
- Request: type=0 -> destination bytes 8-13 all FF, opcode bytes 28-29 = 00 01, target-MAC bytes 40-45 all 00, pad bytes 50-67 all 00.
- Back-to-back: en pulses at N and N+5 -> only one frame. en held high through busy -> next tx_en rises exactly 72+1+IFG_CYCLES+1 cycles after the first rise.
- Reset mid-frame: i_rst=1 at byte 30 -> tx_en=0, data=0, busy=0 at that edge, no done. A request after reset yields a clean 72-byte frame with correct FCS.
- Input stability: change i_arp_desmac_addr and i_arp_desip_addr every cycle after acceptance -> emitted fields still equal the values latched at N.

Source files
------------

// File: rtl/arp_pkg.sv
// Shared constants and FSM state type for the ARP transmit path.
// The UDP transmitter will import the CRC constants from here too.
package arp_pkg;

   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ARP_HTYPE     = 16'h0001;
   localparam logic [15:0] ARP_PTYPE     = 16'h0800;
   localparam logic [7:0]  ARP_HLEN      = 8'h06;
   localparam logic [7:0]  ARP_PLEN      = 8'h04;
   localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
   localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam int PREAMBLE_LEN = 8;
   localparam int ETH_HEAD_LEN = 14;
   localparam int ARP_BODY_LEN = 28;
   localparam int PAD_LEN      = 18;
   localparam int FCS_LEN      = 4;

   // Reflected IEEE 802.3 polynomial (04C1_1DB7 bit-reversed).
   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_ETH_HEAD,
      ST_ARP_BODY,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } state_t;

endpackage

// File: rtl/arp_tx_if.sv
// Request and GMII signals of the ARP transmitter, plus FSM state for debug.
// Handshake: i_arp_tx_en is a one-cycle request taken only while o_arp_tx_busy=0; there is no ready/queue.
interface arp_tx_if;
   import arp_pkg::*;

   logic         i_arp_tx_en;
   logic         i_arp_tx_type;
   logic [47:0]  i_arp_desmac_addr;
   logic [31:0]  i_arp_desip_addr;
   logic         o_gmii_tx_en;
   logic [7:0]   o_gmii_tx_data;
   logic         o_arp_tx_done;
   logic         o_arp_tx_busy;
   state_t       o_dbg_state;

   modport master (
      output i_arp_tx_en, i_arp_tx_type, i_arp_desmac_addr, i_arp_desip_addr,
      input  o_gmii_tx_en, o_gmii_tx_data, o_arp_tx_done, o_arp_tx_busy, o_dbg_state
   );

   modport slave (
      input  i_arp_tx_en, i_arp_tx_type, i_arp_desmac_addr, i_arp_desip_addr,
      output o_gmii_tx_en, o_gmii_tx_data, o_arp_tx_done, o_arp_tx_busy, o_dbg_state
   );

endinterface

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32 for one data byte.
module crc32_d8
   import arp_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] w_c;

   always_comb begin
      w_c = i_crc ^ {24'h0, i_data};
      for (int i = 0; i < 8; i++) begin
         w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY_REFL) : (w_c >> 1);
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/arp_tx.sv
// GMII ARP frame transmitter: preamble, Ethernet header, ARP body, pad and FCS,
// followed by an inter-frame gap during which new requests are dropped.
module arp_tx
   import arp_pkg::*;
#(
   parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
   parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
   parameter int          IFG_CYCLES = 12
) (
   input  logic      i_gmii_tx_clk,
   input  logic      i_rst,
   arp_tx_if.slave   bus
);

   state_t       r_state;
   logic [7:0]   r_cnt;
   logic [31:0]  r_crc;
   logic         r_tx_en;
   logic [7:0]   r_tx_data;
   logic         r_done;
   logic         r_busy;
   logic         r_type;
   logic [47:0]  r_mac;
   logic [31:0]  r_ip;

   logic [47:0]  w_dst_mac;
   logic [47:0]  w_tgt_mac;
   logic [15:0]  w_opcode;
   logic [111:0] w_eth_hdr;
   logic [223:0] w_arp_body;
   logic [6:0]   w_eth_idx;
   logic [7:0]   w_arp_idx;
   logic [4:0]   w_fcs_idx;
   logic [31:0]  w_fcs;
   logic [7:0]   w_fcs_byte;
   logic [7:0]   w_payload_byte;
   logic         w_last_payload;
   state_t       w_next_state;
   logic [31:0]  w_crc_next;

   assign w_dst_mac  = r_type ? r_mac : 48'hFFFF_FFFF_FFFF;
   assign w_tgt_mac  = r_type ? r_mac : 48'h0;
   assign w_opcode   = r_type ? ARP_OP_REPLY : ARP_OP_REQ;
   assign w_eth_hdr  = {w_dst_mac, BOARD_MAC, ETH_TYPE_ARP};
   assign w_arp_body = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, w_opcode,
                        BOARD_MAC, BOARD_IP, w_tgt_mac, r_ip};

   // Byte n of a field sits at bit offset 8*(LEN-1-n) because fields go MSB first.
   assign w_eth_idx  = 7'(8 * (ETH_HEAD_LEN - 1)) - {r_cnt[3:0], 3'b000};
   assign w_arp_idx  = 8'(8 * (ARP_BODY_LEN - 1)) - {r_cnt[4:0], 3'b000};
   assign w_fcs_idx  = {r_cnt[1:0], 3'b000};
   assign w_fcs      = ~r_crc;
   assign w_fcs_byte = w_fcs[w_fcs_idx +: 8];

   always_comb begin
      w_payload_byte = 8'h00;
      w_last_payload = 1'b0;
      w_next_state   = ST_IDLE;
      case (r_state)
         ST_ETH_HEAD: begin
            w_payload_byte = w_eth_hdr[w_eth_idx +: 8];
            w_last_payload = (r_cnt == 8'(ETH_HEAD_LEN - 1));
            w_next_state   = ST_ARP_BODY;
         end
         ST_ARP_BODY: begin
            w_payload_byte = w_arp_body[w_arp_idx +: 8];
            w_last_payload = (r_cnt == 8'(ARP_BODY_LEN - 1));
            w_next_state   = ST_PAD;
         end
         ST_PAD: begin
            w_last_payload = (r_cnt == 8'(PAD_LEN - 1));
            w_next_state   = ST_FCS;
         end
         default: ;
      endcase
   end

   crc32_d8 u_crc32_d8 (
      .i_crc  (r_crc),
      .i_data (w_payload_byte),
      .o_crc  (w_crc_next)
   );

   always_ff @(posedge i_gmii_tx_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 8'd0;
         r_crc     <= CRC_INIT;
         r_tx_en   <= 1'b0;
         r_tx_data <= 8'h00;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_type    <= 1'b0;
         r_mac     <= 48'h0;
         r_ip      <= 32'h0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tx_en   <= 1'b0;
               r_tx_data <= 8'h00;
               if (bus.i_arp_tx_en) begin
                  r_type  <= bus.i_arp_tx_type;
                  r_mac   <= bus.i_arp_desmac_addr;
                  r_ip    <= bus.i_arp_desip_addr;
                  r_busy  <= 1'b1;
                  r_cnt   <= 8'd0;
                  r_state <= ST_PREAMBLE;
               end
            end
            ST_PREAMBLE: begin
               r_tx_en <= 1'b1;
               if (r_cnt == 8'(PREAMBLE_LEN - 1)) begin
                  r_tx_data <= SFD_BYTE;
                  r_crc     <= CRC_INIT;
                  r_cnt     <= 8'd0;
                  r_state   <= ST_ETH_HEAD;
               end else begin
                  r_tx_data <= PREAMBLE_BYTE;
                  r_cnt     <= r_cnt + 8'd1;
               end
            end
            ST_ETH_HEAD, ST_ARP_BODY, ST_PAD: begin
               r_tx_en   <= 1'b1;
               r_tx_data <= w_payload_byte;
               r_crc     <= w_crc_next;
               if (w_last_payload) begin
                  r_cnt   <= 8'd0;
                  r_state <= w_next_state;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_FCS: begin
               r_tx_en   <= 1'b1;
               r_tx_data <= w_fcs_byte;
               if (r_cnt == 8'(FCS_LEN - 1)) begin
                  r_cnt   <= 8'd0;
                  r_state <= ST_IFG;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_IFG: begin
               // First IFG cycle carries the done pulse; IFG_CYCLES more idle cycles follow.
               r_tx_en   <= 1'b0;
               r_tx_data <= 8'h00;
               r_done    <= (r_cnt == 8'd0);
               if (r_cnt == 8'(IFG_CYCLES)) begin
                  r_busy  <= 1'b0;
                  r_cnt   <= 8'd0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_gmii_tx_en   = r_tx_en;
   assign bus.o_gmii_tx_data = r_tx_data;
   assign bus.o_arp_tx_done  = r_done;
   assign bus.o_arp_tx_busy  = r_busy;
   assign bus.o_dbg_state    = r_state;

endmodule

// File: tb/tb_arp_tx.sv
// Directed bench for arp_tx: captures GMII bytes and compares them to an expected-byte queue.
module tb_arp_tx;
   import arp_pkg::*;

   localparam logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55;
   localparam logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10};
   localparam int          IFG        = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [7:0] cap_q[$];
   logic [7:0] exp_q[$];
   int   rise_cnt = 0;
   int   done_cnt = 0;
   int   last_rise = 0;
   int   last_done = 0;
   logic prev_en = 1'b0;

   arp_tx_if bus ();

   arp_tx #(
      .BOARD_MAC  (BOARD_MAC),
      .BOARD_IP   (BOARD_IP),
      .IFG_CYCLES (IFG)
   ) dut (
      .i_gmii_tx_clk (clk),
      .i_rst         (rst),
      .bus           (bus)
   );

   // ---------------- clock / reset block ----------------
   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "global timeout");
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (bus.o_gmii_tx_en) begin
         cap_q.push_back(bus.o_gmii_tx_data);
         if (!prev_en) begin
            rise_cnt  = rise_cnt + 1;
            last_rise = cyc;
         end
      end
      if (bus.o_arp_tx_done) begin
         done_cnt  = done_cnt + 1;
         last_done = cyc;
      end
      prev_en = bus.o_gmii_tx_en;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] sw_crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      logic        fb;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ d[i];
         c  = c >> 1;
         if (fb) c = c ^ 32'hEDB8_8320;
      end
      return c;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_field(input logic [63:0] v, input int nbytes);
      for (int i = nbytes - 1; i >= 0; i--) exp_q.push_back(8'(v >> (8 * i)));
   endtask

   task automatic build_exp(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
      logic [31:0] c;
      logic [31:0] fcs;
      exp_q.delete();
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      push_field(typ ? {16'h0, mac} : 64'h0000_FFFF_FFFF_FFFF, 6);
      push_field({16'h0, BOARD_MAC}, 6);
      push_field(64'h0806, 2);
      push_field(64'h0001, 2);
      push_field(64'h0800, 2);
      push_field(64'h06, 1);
      push_field(64'h04, 1);
      push_field(typ ? 64'h0002 : 64'h0001, 2);
      push_field({16'h0, BOARD_MAC}, 6);
      push_field({32'h0, BOARD_IP}, 4);
      push_field(typ ? {16'h0, mac} : 64'h0, 6);
      push_field({32'h0, ip}, 4);
      repeat (18) exp_q.push_back(8'h00);
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 68; i++) c = sw_crc_byte(c, exp_q[i]);
      fcs = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
   endtask

   task automatic send(input logic typ, input logic [47:0] mac, input logic [31:0] ip, output int n);
      bus.i_arp_tx_type     = typ;
      bus.i_arp_desmac_addr = mac;
      bus.i_arp_desip_addr  = ip;
      bus.i_arp_tx_en       = 1'b1;
      tick();
      n = cyc;
      bus.i_arp_tx_en = 1'b0;
      check("busy_at_accept", 64'(bus.o_arp_tx_busy), 64'd1);
   endtask

   task automatic wait_done(input int max_cyc, input bit perturb);
      int start;
      int k;
      start = done_cnt;
      k = 0;
      while (done_cnt == start && k < max_cyc) begin
         tick();
         if (perturb) begin
            bus.i_arp_desmac_addr = {16'($urandom), 32'($urandom)};
            bus.i_arp_desip_addr  = 32'($urandom);
         end
         k++;
      end
      check("done_seen", 64'(done_cnt != start), 64'd1);
      check("tx_en_low_in_done", 64'(bus.o_gmii_tx_en), 64'd0);
   endtask

   task automatic check_frame(input string tag);
      logic [31:0] c;
      check({tag, "_len"}, 64'(cap_q.size()), 64'd72);
      for (int i = 0; i < 72; i++)
         check($sformatf("%s_byte%0d", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 72; i++) c = sw_crc_byte(c, cap_q[i]);
      check({tag, "_residue"}, 64'(bitrev32(c)), 64'hC704_DD7B);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int d0;
      int r0;
      int r1;
      int k;
      logic [7:0] reply_dst[6];
      logic [7:0] reply_ip[4];

      reply_dst = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5};
      reply_ip  = '{8'hC0, 8'hA8, 8'h01, 8'h66};

      bus.i_arp_tx_en       = 1'b0;
      bus.i_arp_tx_type     = 1'b0;
      bus.i_arp_desmac_addr = 48'h0;
      bus.i_arp_desip_addr  = 32'h0;
      rst = 1'b1;
      repeat (4) tick();
      check("rst_tx_en", 64'(bus.o_gmii_tx_en), 64'd0);
      check("rst_tx_data", 64'(bus.o_gmii_tx_data), 64'd0);
      check("rst_done", 64'(bus.o_arp_tx_done), 64'd0);
      check("rst_busy", 64'(bus.o_arp_tx_busy), 64'd0);
      check("rst_state", 64'(bus.o_dbg_state), 64'(ST_IDLE));
      rst = 1'b0;
      repeat (3) tick();

      // Reply, with addresses scrambled every cycle after acceptance.
      build_exp(1'b1, 48'hA0B1_C2D3_E4F5, {8'd192, 8'd168, 8'd1, 8'd102});
      cap_q.delete();
      d0 = done_cnt;
      send(1'b1, 48'hA0B1_C2D3_E4F5, {8'd192, 8'd168, 8'd1, 8'd102}, n);
      wait_done(150, 1'b1);
      check("reply_rise_lat", 64'(last_rise - n), 64'd1);
      check("reply_done_lat", 64'(last_done - n), 64'd73);
      tick();
      check("reply_done_width", 64'(done_cnt - d0), 64'd1);
      check("reply_done_low", 64'(bus.o_arp_tx_done), 64'd0);
      for (int i = 0; i < 6; i++) check($sformatf("reply_dst%0d", i), 64'(cap_q[8+i]), 64'(reply_dst[i]));
      check("reply_etype0", 64'(cap_q[20]), 64'h08);
      check("reply_etype1", 64'(cap_q[21]), 64'h06);
      check("reply_op0", 64'(cap_q[28]), 64'h00);
      check("reply_op1", 64'(cap_q[29]), 64'h02);
      for (int i = 0; i < 4; i++) check($sformatf("reply_tip%0d", i), 64'(cap_q[46+i]), 64'(reply_ip[i]));
      check_frame("reply");
      repeat (IFG + 4) tick();
      check("reply_busy_end", 64'(bus.o_arp_tx_busy), 64'd0);

      // Request: MAC input must be ignored.
      build_exp(1'b0, 48'h0A0B_0C0D_0E0F, {8'd192, 8'd168, 8'd1, 8'd1});
      cap_q.delete();
      send(1'b0, 48'h0A0B_0C0D_0E0F, {8'd192, 8'd168, 8'd1, 8'd1}, n);
      wait_done(150, 1'b0);
      for (int i = 8; i < 14; i++) check($sformatf("req_dst%0d", i), 64'(cap_q[i]), 64'hFF);
      check("req_op0", 64'(cap_q[28]), 64'h00);
      check("req_op1", 64'(cap_q[29]), 64'h01);
      for (int i = 40; i < 46; i++) check($sformatf("req_tmac%0d", i), 64'(cap_q[i]), 64'h00);
      for (int i = 50; i < 68; i++) check($sformatf("req_pad%0d", i), 64'(cap_q[i]), 64'h00);
      check_frame("req");
      repeat (IFG + 4) tick();

      // Second pulse at N+5 while busy is dropped.
      r0 = rise_cnt;
      cap_q.delete();
      send(1'b0, 48'h0, 32'h0102_0304, n);
      repeat (4) tick();
      bus.i_arp_tx_en = 1'b1;
      tick();
      bus.i_arp_tx_en = 1'b0;
      wait_done(150, 1'b0);
      repeat (IFG + 10) tick();
      check("b2b_frames", 64'(rise_cnt - r0), 64'd1);
      check("b2b_len", 64'(cap_q.size()), 64'd72);
      check("b2b_busy_end", 64'(bus.o_arp_tx_busy), 64'd0);

      // Request held high: next frame starts right after the gap.
      r0 = rise_cnt;
      bus.i_arp_tx_type     = 1'b1;
      bus.i_arp_desmac_addr = 48'h1234_5678_9ABC;
      bus.i_arp_desip_addr  = 32'hC0A8_0107;
      bus.i_arp_tx_en       = 1'b1;
      k = 0;
      while (rise_cnt < r0 + 1 && k < 100) begin tick(); k++; end
      r1 = last_rise;
      k = 0;
      while (rise_cnt < r0 + 2 && k < 200) begin tick(); k++; end
      check("held_frames", 64'(rise_cnt - r0), 64'd2);
      check("held_spacing", 64'(last_rise - r1), 64'(72 + 1 + IFG + 1));
      bus.i_arp_tx_en = 1'b0;
      wait_done(150, 1'b0);
      repeat (IFG + 4) tick();

      // Reset while byte 30 is on the wire.
      cap_q.delete();
      d0 = done_cnt;
      r0 = rise_cnt;
      send(1'b0, 48'h0, 32'hC0A8_0109, n);
      k = 0;
      while (cap_q.size() < 31 && k < 100) begin tick(); k++; end
      check("mid_reached_byte30", 64'(cap_q.size()), 64'd31);
      rst = 1'b1;
      tick();
      check("mid_rst_tx_en", 64'(bus.o_gmii_tx_en), 64'd0);
      check("mid_rst_data", 64'(bus.o_gmii_tx_data), 64'd0);
      check("mid_rst_busy", 64'(bus.o_arp_tx_busy), 64'd0);
      rst = 1'b0;
      repeat (90) tick();
      check("mid_no_done", 64'(done_cnt - d0), 64'd0);
      check("mid_no_restart", 64'(rise_cnt - r0), 64'd1);

      build_exp(1'b1, 48'hDEAD_BEEF_0001, 32'hC0A8_0142);
      cap_q.delete();
      send(1'b1, 48'hDEAD_BEEF_0001, 32'hC0A8_0142, n);
      wait_done(150, 1'b0);
      check("post_rst_done_lat", 64'(last_done - n), 64'd73);
      check_frame("post_rst");
      repeat (IFG + 4) tick();

      // ---------------- final report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
